// File: rtl/signed_mod_accumulator.sv
// signed_mod_accumulator
// Steps the term mux through select codes 1..7, one term per clock, and adds
// the enabled 8-bit terms modulo MOD. The final residue is then mapped into
// the signed centred range [-(MOD-HALF-1), HALF] and presented as a 9-bit
// two's-complement result together with a one-cycle done strobe.
//
// Handshake: start is sampled only in IDLE. Once accepted, busy stays high
// until the cycle done pulses. Any start seen while busy is ignored, and
// term_mask is only captured together with an accepted start.
module signed_mod_accumulator #(
  parameter int MOD  = 255,
  parameter int HALF = (MOD - 1) / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] term_mask,
  input  logic [7:0] mux_outp,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [8:0] result,
  output logic [1:0] dbg_state
);

  localparam logic [8:0] MOD_W  = 9'(MOD);
  localparam logic [8:0] HALF_W = 9'(HALF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t     state_q,   state_d;
  logic [2:0] counter_q, counter_d;
  logic [6:0] mask_q,    mask_d;
  logic [7:0] acc_q,     acc_d;
  logic [2:0] sel_q,     sel_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic [8:0] result_q,  result_d;

  // Datapath signals for one accumulation step and for the final mapping.
  logic [8:0] term_ext;
  logic [8:0] term_red;
  logic [8:0] sum;
  logic [8:0] sum_red;
  logic [7:0] mask_ext;
  logic       term_en;
  logic [8:0] acc_ext;
  logic [8:0] fix_val;

  // One modular accumulation step and the signed mapping of the residue.
  // Because MOD >= 128, a reduced term is below MOD, so a single conditional
  // subtraction keeps the sum in [0, MOD-1].
  always_comb begin
    term_ext = {1'b0, mux_outp};
    term_red = (term_ext >= MOD_W) ? (term_ext - MOD_W) : term_ext;
    acc_ext  = {1'b0, acc_q};
    sum      = acc_ext + term_red;
    sum_red  = (sum >= MOD_W) ? (sum - MOD_W) : sum;
    mask_ext = {1'b0, mask_q};
    term_en  = mask_ext[counter_q - 3'd1];
    // 9-bit wraparound of acc - MOD yields its two's-complement encoding.
    fix_val  = (acc_ext > HALF_W) ? (acc_ext - MOD_W) : acc_ext;
  end

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    mask_d    = mask_q;
    acc_d     = acc_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          mask_d    = term_mask;
          acc_d     = 8'd0;
          counter_d = 3'd1;
          sel_d     = 3'd1;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (term_en) begin
          acc_d = sum_red[7:0];
        end
        if (counter_q == 3'd7) begin
          counter_d = 3'd0;
          sel_d     = 3'd0;
          state_d   = S_FIX;
        end else begin
          counter_d = counter_q + 3'd1;
          sel_d     = counter_q + 3'd1;
        end
      end

      S_FIX: begin
        result_d = fix_val;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        sel_d    = 3'd0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        counter_d = 3'd0;
        sel_d     = 3'd0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      counter_q <= 3'd0;
      mask_q    <= 7'd0;
      acc_q     <= 8'd0;
      sel_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 9'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      mask_q    <= mask_d;
      acc_q     <= acc_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: doc/signed_mod_accumulator.md
Name: signed_mod_accumulator

Overview:
- Sequencer/accumulator directly downstream of the 7-way term mux in the signed reverse converter.
- Walks mux select codes 1..7, one term per cycle, and accumulates the selected 8-bit partial terms modulo MOD.
- Maps the final residue into signed centred range and presents it with a one-cycle done strobe to the output stage.

Parameters:
- MOD, 255, accumulation modulus; legal range 128..255.
- HALF, (MOD-1)/2, largest non-negative result; residues above HALF map to negative values.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new conversion; sampled only in IDLE.
- term_mask  input  7  bit i enables term for sel code i+1; sampled with start.
- mux_outp  input  8  term from the mux, combinationally dependent on sel.
- sel  output  3  select code driven to the mux.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse when result is updated.
- result  output  9  signed two's-complement converted value; held until the next done.

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=0, busy=0, done=0, result=0, accumulator=0, counter=0, mask register=0. Reset mid-conversion aborts immediately; no done is produced.
- States:
  - IDLE
  - RUN: counter 1..7.
  - FIX
- IDLE:
  - sel=0.
  - On rising edge with start=1: capture term_mask, clear accumulator, counter<=1, go to RUN, busy<=1.
- RUN:
  - sel=counter, registered, so mux_outp is valid in the same cycle.
  - At each edge, if mask[counter-1]=1: t = (mux_outp >= MOD) ? mux_outp-MOD : mux_outp; s = acc + t as 9-bit; acc <= (s >= MOD) ? s-MOD : s. Otherwise acc holds.
  - Counter increments; after processing counter=7, go to FIX with sel<=0.
- FIX (one cycle):
  - result <= (acc > HALF) ? acc - MOD, sign-extended to 9 bits : {1'b0, acc}.
  - done<=1 for exactly one cycle, busy<=0, return to IDLE.
- Latency: start sampled at edge k; terms accumulated at edges k+1..k+7; result/done registered at edge k+8. done is high during cycle k+8 to k+9. Next start is accepted at edge k+9 at the earliest; back-to-back throughput is 9 cycles per conversion.
- start while busy (RUN or FIX) is ignored; term_mask changes during RUN have no effect.
- term_mask=0: result=0, done still pulses at k+8.
- Arithmetic invariants: acc always in [0, MOD-1]; result always in [-(MOD-HALF-1), HALF]. For MOD=255, the range is -127..+127.
- The accumulator never exceeds 9 bits. Since MOD ≥ 128 guarantees t < MOD, a single conditional subtraction per step is sufficient.
- sel is never driven to 0 during RUN and never nonzero outside RUN.

Test Plan:
- MOD=255; the bench models the mux so that mux_outp=1 for every sel; start with term_mask=7'h7F. Expected: sel sequence 1,2,…,7 on consecutive cycles, done at k+8, result=+7 (9'h007), busy high for 8 cycles.
- Bench mux returns 200 for sel=1 and 100 for sel=2; term_mask=7'h03. Expected: 300 mod 255 = 45, so result=+45 (9'h02D).
- Bench mux returns 200 for sel=1; term_mask=7'h01. Expected: 200 > 127, so result=-55 (9'h1C9). Repeat with mux_outp=255 and term_mask=7'h01: 255 reduces to 0, so result=0.
- During RUN, assert start again and toggle term_mask. Expected: exactly one done at k+8 with the original result; no second conversion starts. A start at k+9 is accepted.
- Assert rst asynchronously mid-cycle during RUN at counter=4. Expected: sel, busy, done and result go to 0 immediately, with no done pulse. A following conversion with term_mask=7'h7F and all terms 1 gives result=+7.
